// File: rtl/spi_midi_parser_pkg.sv
// Shared constants and types for the SPI-fed MIDI channel-voice parser.
// Covers message type codes, status nibbles, the realtime threshold and the parser state encoding.
package spi_midi_parser_pkg;

  localparam logic [1:0] MSG_NOTE_OFF = 2'd0;
  localparam logic [1:0] MSG_NOTE_ON  = 2'd1;
  localparam logic [1:0] MSG_CTRL     = 2'd2;

  localparam logic [3:0] STAT_NOTE_OFF = 4'h8;
  localparam logic [3:0] STAT_NOTE_ON  = 4'h9;
  localparam logic [3:0] STAT_CTRL     = 4'hB;
  localparam logic [3:0] STAT_SYSTEM   = 4'hF;

  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } parse_state_t;

  // Status nibbles whose messages are assembled and forwarded; every other voice status is skipped.
  function automatic logic is_tracked_status(input logic [3:0] hi);
    return (hi == STAT_NOTE_OFF) || (hi == STAT_NOTE_ON) || (hi == STAT_CTRL);
  endfunction

endpackage

// File: rtl/spi_midi_parser_if.sv
// Message bus from the parser's one-entry output buffer to the voice allocator.
// Uses a valid/ready handshake; the payload is held stable while valid is high and ready is low.
interface spi_midi_parser_if;
  logic       o_msg_valid;
  logic       i_msg_ready;
  logic [1:0] o_msg_type;
  logic [3:0] o_msg_chan;
  logic [6:0] o_msg_d1;
  logic [6:0] o_msg_d2;

  modport master (
    output o_msg_valid, o_msg_type, o_msg_chan, o_msg_d1, o_msg_d2,
    input  i_msg_ready
  );

  modport slave (
    input  o_msg_valid, o_msg_type, o_msg_chan, o_msg_d1, o_msg_d2,
    output i_msg_ready
  );
endinterface

// File: rtl/spi_midi_parser_sync_edge_detect.sv
// Two-flop synchronizer followed by a rising-edge detector, producing a single-cycle pulse.
// Intended for level flags arriving from the SPI clock domain.
module sync_edge_detect (
  input  logic i_sys_clk,
  input  logic i_sys_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic meta_reg;
  logic sync_reg;
  logic sync_d_reg;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      meta_reg   <= 1'b0;
      sync_reg   <= 1'b0;
      sync_d_reg <= 1'b0;
    end else begin
      meta_reg   <= i_async;
      sync_reg   <= meta_reg;
      sync_d_reg <= sync_reg;
    end
  end

  assign o_rise = sync_reg & ~sync_d_reg;

endmodule

// File: rtl/spi_midi_parser.sv
// MIDI channel-voice parser with running status, fed one byte at a time by the SPI receiver.
// Note-off, note-on and control-change messages are forwarded through a one-entry valid/ready buffer.
module spi_midi_parser
  import spi_midi_parser_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter logic       OMNI    = 1'b0
) (
  input  logic                      i_sys_clk,
  input  logic                      i_sys_rst_n,
  input  logic [7:0]                i_data,
  input  logic                      i_data_load,
  spi_midi_parser_if.master         msg_if,
  output logic                      o_overflow
);

  logic         byte_take;
  parse_state_t state_reg, state_next;
  logic [7:0]   status_reg, status_next;
  logic [6:0]   d1_reg, d1_next;
  logic         msg_done;
  logic [1:0]   done_type;
  logic         chan_match;
  logic         buf_load;

  sync_edge_detect u_load_sync (
    .i_sys_clk   (i_sys_clk),
    .i_sys_rst_n (i_sys_rst_n),
    .i_async     (i_data_load),
    .o_rise      (byte_take)
  );

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_reg  <= IDLE;
      status_reg <= 8'h00;
      d1_reg     <= 7'h00;
    end else begin
      state_reg  <= state_next;
      status_reg <= status_next;
      d1_reg     <= d1_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    status_next = status_reg;
    d1_next     = d1_reg;
    msg_done    = 1'b0;
    if (byte_take && (i_data < REALTIME_MIN)) begin
      if (i_data[7:4] == STAT_SYSTEM) begin
        state_next  = IDLE;
        status_next = 8'h00;
      end else if (i_data[7]) begin
        // Skipped statuses park in IDLE: their data bytes then fall through and are dropped.
        status_next = i_data;
        state_next  = is_tracked_status(i_data[7:4]) ? WAIT_D1 : IDLE;
      end else begin
        case (state_reg)
          WAIT_D1: begin
            d1_next    = i_data[6:0];
            state_next = WAIT_D2;
          end
          WAIT_D2: begin
            msg_done   = 1'b1;
            state_next = WAIT_D1;
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (status_reg[7:4])
      STAT_NOTE_ON: done_type = (i_data[6:0] == 7'h00) ? MSG_NOTE_OFF : MSG_NOTE_ON;
      STAT_CTRL:    done_type = MSG_CTRL;
      default:      done_type = MSG_NOTE_OFF;
    endcase
  end

  assign chan_match = OMNI || (status_reg[3:0] == CHANNEL);
  assign buf_load   = msg_done && chan_match;

  // A pop in the same cycle frees the slot, so a new message may replace the outgoing one.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      msg_if.o_msg_valid <= 1'b0;
      msg_if.o_msg_type  <= 2'd0;
      msg_if.o_msg_chan  <= 4'd0;
      msg_if.o_msg_d1    <= 7'd0;
      msg_if.o_msg_d2    <= 7'd0;
      o_overflow         <= 1'b0;
    end else if (buf_load && (!msg_if.o_msg_valid || msg_if.i_msg_ready)) begin
      msg_if.o_msg_valid <= 1'b1;
      msg_if.o_msg_type  <= done_type;
      msg_if.o_msg_chan  <= status_reg[3:0];
      msg_if.o_msg_d1    <= d1_reg;
      msg_if.o_msg_d2    <= i_data[6:0];
    end else begin
      if (buf_load) begin
        o_overflow <= 1'b1;
      end
      if (msg_if.o_msg_valid && msg_if.i_msg_ready) begin
        msg_if.o_msg_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_midi_parser.sv
// Self-checking bench: an OMNI parser and a channel-2-only parser share one byte stream;
// expected messages are queued as bytes are sent and popped as each buffer is drained.
module tb_spi_midi_parser;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       load;
  logic       ready;
  logic       ovf_a;
  logic       ovf_b;

  int n_checks;
  int n_fail;

  spi_midi_parser_if bus_a ();
  spi_midi_parser_if bus_b ();

  assign bus_a.i_msg_ready = ready;
  assign bus_b.i_msg_ready = ready;

  spi_midi_parser #(.CHANNEL(4'd0), .OMNI(1'b1)) dut_a (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .i_data      (data),
    .i_data_load (load),
    .msg_if      (bus_a),
    .o_overflow  (ovf_a)
  );

  spi_midi_parser #(.CHANNEL(4'd2), .OMNI(1'b0)) dut_b (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .i_data      (data),
    .i_data_load (load),
    .msg_if      (bus_b),
    .o_overflow  (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] bytes;
    int          n;
    logic [39:0] ea;
    int          na;
    logic [39:0] eb;
    int          nb;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] exp_a[$];
  logic [19:0] exp_b[$];

  function automatic logic [19:0] msg(input logic [1:0] t, input logic [3:0] c,
                                      input logic [6:0] d1, input logic [6:0] d2);
    return {t, c, d1, d2};
  endfunction

  task automatic add_vec(input logic [47:0] bytes, input int n,
                         input logic [39:0] ea, input int na,
                         input logic [39:0] eb, input int nb);
    vec_t v;
    v.bytes = bytes; v.n = n; v.ea = ea; v.na = na; v.eb = eb; v.nb = nb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    data = b;
    load = 1'b1;
    repeat (4) @(posedge clk);
    #1 load = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic drain_check(input string tag);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_left_a"}, exp_a.size(), 0);
    check({tag, "_left_b"}, exp_b.size(), 0);
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_a.delete();
    exp_b.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic monitor_one(input string name, input logic v, input logic [19:0] got,
                             inout logic [19:0] q[$]);
    logic [19:0] e;
    if (v) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_unexpected: got %05h, expected no message", name, got);
      end else begin
        e = q.pop_front();
        check(name, {12'h0, got}, {12'h0, e});
        $display("pop %s: %05h", name, got);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    data     = 8'h00;
    load     = 1'b0;
    ready    = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && ready) begin
          monitor_one("msg_a", bus_a.o_msg_valid,
                      {bus_a.o_msg_type, bus_a.o_msg_chan, bus_a.o_msg_d1, bus_a.o_msg_d2}, exp_a);
          monitor_one("msg_b", bus_b.o_msg_valid,
                      {bus_b.o_msg_type, bus_b.o_msg_chan, bus_b.o_msg_d1, bus_b.o_msg_d2}, exp_b);
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus_a.o_msg_valid, 0);
    check("rst_fields", {bus_a.o_msg_type, bus_a.o_msg_chan, bus_a.o_msg_d1, bus_a.o_msg_d2}, 0);
    check("rst_ovf", ovf_a, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rel_valid", bus_a.o_msg_valid, 0);

    add_vec(48'h903C64000000, 3, {msg(1,0,7'h3C,7'h64), 20'h0}, 1, 40'h0, 0);
    add_vec(48'h914050410000, 5, {msg(1,1,7'h40,7'h50), msg(0,1,7'h41,7'h00)}, 2, 40'h0, 0);
    add_vec(48'h903CF8640000, 4, {msg(1,0,7'h3C,7'h64), 20'h0}, 1, 40'h0, 0);
    add_vec(48'h903CB0077F00, 5, {msg(2,0,7'h07,7'h7F), 20'h0}, 1, 40'h0, 0);
    add_vec(48'h931020000000, 3, {msg(1,3,7'h10,7'h20), 20'h0}, 1, 40'h0, 0);
    add_vec(48'h921020000000, 3, {msg(1,2,7'h10,7'h20), 20'h0}, 1, {msg(1,2,7'h10,7'h20), 20'h0}, 1);
    add_vec(48'h820506000000, 3, {msg(0,2,7'h05,7'h06), 20'h0}, 1, {msg(0,2,7'h05,7'h06), 20'h0}, 1);
    add_vec(48'hC20506070000, 4, 40'h0, 0, 40'h0, 0);
    add_vec(48'hE20102030000, 4, 40'h0, 0, 40'h0, 0);
    add_vec(48'h9201F3020000, 4, 40'h0, 0, 40'h0, 0);
    add_vec(48'hF01020000000, 3, 40'h0, 0, 40'h0, 0);
    add_vec(48'hB57F00000000, 3, {msg(2,5,7'h7F,7'h00), 20'h0}, 1, 40'h0, 0);
    add_vec(48'h921122334400, 5, {msg(1,2,7'h11,7'h22), msg(1,2,7'h33,7'h44)}, 2,
                                 {msg(1,2,7'h11,7'h22), msg(1,2,7'h33,7'h44)}, 2);

    foreach (vecs[vi]) begin
      logic [47:0] bs;
      bs = vecs[vi].bytes;
      for (int k = 0; k < vecs[vi].na; k++) exp_a.push_back(vecs[vi].ea[39 - 20*k -: 20]);
      for (int k = 0; k < vecs[vi].nb; k++) exp_b.push_back(vecs[vi].eb[39 - 20*k -: 20]);
      for (int k = 0; k < vecs[vi].n; k++) send_byte(bs[47 - 8*k -: 8]);
      drain_check($sformatf("vec%0d", vi));
    end

    // Latency, single-cycle valid and a load flag held high for 20 cycles
    exp_a.push_back(msg(1,0,7'h3C,7'h64));
    exp_a.push_back(msg(1,0,7'h3D,7'h70));
    send_byte(8'h90);
    send_byte(8'h3C);
    @(posedge clk); #1;
    data = 8'h64;
    load = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("lat_early", bus_a.o_msg_valid, 0);
    @(posedge clk);
    #1 check("lat_on", bus_a.o_msg_valid, 1);
    @(posedge clk);
    #1 check("one_cycle", bus_a.o_msg_valid, 0);
    repeat (16) @(posedge clk);
    #1 load = 1'b0;
    repeat (4) @(posedge clk);
    send_byte(8'h3D);
    send_byte(8'h70);
    drain_check("held");

    // Full buffer: first message held, second dropped, overflow set
    @(posedge clk); #1 ready = 1'b0;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    #1;
    check("full_valid", bus_a.o_msg_valid, 1);
    check("full_msg", {bus_a.o_msg_type, bus_a.o_msg_chan, bus_a.o_msg_d1, bus_a.o_msg_d2},
          msg(1,0,7'h3C,7'h64));
    check("full_ovf0", ovf_a, 0);
    send_byte(8'h90); send_byte(8'h3D); send_byte(8'h65);
    #1;
    check("hold_msg", {bus_a.o_msg_type, bus_a.o_msg_chan, bus_a.o_msg_d1, bus_a.o_msg_d2},
          msg(1,0,7'h3C,7'h64));
    check("ovf_set", ovf_a, 1);
    check("ovf_b_clear", ovf_b, 0);
    check("b_filtered", bus_b.o_msg_valid, 0);
    exp_a.push_back(msg(1,0,7'h3C,7'h64));
    @(posedge clk); #1 ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("popped_valid", bus_a.o_msg_valid, 0);
    check("ovf_sticky", ovf_a, 1);
    drain_check("ovf");

    // Reset with a buffered entry and a partial message pending
    @(posedge clk); #1 ready = 1'b0;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    send_byte(8'h90); send_byte(8'h3C);
    do_reset();
    check("mid_rst_valid", bus_a.o_msg_valid, 0);
    check("mid_rst_ovf", ovf_a, 0);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("mid_rel_valid", bus_a.o_msg_valid, 0);
    send_byte(8'h64);
    #1 check("lone_data_valid", bus_a.o_msg_valid, 0);
    drain_check("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
